// File: rtl/revelador_papeis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | revelador_papeis: latches the role vector, then reveals roles one by one    |
// |   (hidden -> shown -> hidden) on avanca or auto-hide timeout.  Rev 1.0      |
// +----------------------------------------------------------------------------+
module revelador_papeis #(
  parameter int N_JOGADORES = 10,
  parameter int T_MOSTRA    = 50000000,
  parameter int W_TIMER     = 26
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   avanca,
  input  logic [N_JOGADORES-1:0] jogo_atual,
  output logic [3:0]             jogador_atual,
  output logic                   mostra_papel,
  output logic                   papel,
  output logic [3:0]             num_lobos,
  output logic                   fim,
  output logic                   erro,
  output logic [4:0]             db_estado
);

  typedef enum logic [4:0] {
    OCIOSO    = 5'd0,
    CARREGA   = 5'd1,
    ESCONDIDO = 5'd2,
    MOSTRANDO = 5'd3,
    PROXIMO   = 5'd4,
    FIM       = 5'd5
  } estado_t;

  localparam logic [W_TIMER-1:0] C_TIMER_LIMITE = W_TIMER'(T_MOSTRA - 1);
  localparam logic [3:0]         C_ULTIMO       = 4'(N_JOGADORES - 1);

  estado_t                estado_q, estado_d;
  logic [N_JOGADORES-1:0] jogo_q, jogo_d;
  logic [3:0]             idx_q, idx_d;
  logic [3:0]             lobos_q, lobos_d;
  logic                   erro_q, erro_d;
  logic [W_TIMER-1:0]     timer_q, timer_d;
  logic [3:0]             popcount_w;

  always_comb begin
    popcount_w = 4'd0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      popcount_w = popcount_w + 4'(jogo_q[i]);
    end
  end

  always_comb begin
    estado_d = estado_q;
    jogo_d   = jogo_q;
    idx_d    = idx_q;
    lobos_d  = lobos_q;
    erro_d   = erro_q;
    timer_d  = timer_q;
    case (estado_q)
      OCIOSO, FIM: begin
        if (iniciar) begin
          jogo_d   = jogo_atual;
          idx_d    = 4'd0;
          erro_d   = 1'b0;
          estado_d = CARREGA;
        end
      end
      CARREGA: begin
        lobos_d = popcount_w;
        if (popcount_w == 4'd0) begin
          erro_d   = 1'b1;
          estado_d = FIM;
        end else begin
          estado_d = ESCONDIDO;
        end
      end
      ESCONDIDO: begin
        if (avanca) begin
          timer_d  = '0;
          estado_d = MOSTRANDO;
        end
      end
      MOSTRANDO: begin
        timer_d = timer_q + W_TIMER'(1);
        // A press landing on the timeout cycle still yields a single advance
        if (avanca || (timer_q == C_TIMER_LIMITE)) begin
          estado_d = PROXIMO;
        end
      end
      PROXIMO: begin
        if (idx_q == C_ULTIMO) begin
          estado_d = FIM;
        end else begin
          idx_d    = idx_q + 4'd1;
          estado_d = ESCONDIDO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      jogo_q   <= '0;
      idx_q    <= 4'd0;
      lobos_q  <= 4'd0;
      erro_q   <= 1'b0;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      jogo_q   <= jogo_d;
      idx_q    <= idx_d;
      lobos_q  <= lobos_d;
      erro_q   <= erro_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    mostra_papel  = (estado_q == MOSTRANDO);
    papel         = mostra_papel & jogo_q[idx_q];
    jogador_atual = idx_q;
    num_lobos     = lobos_q;
    fim           = (estado_q == FIM);
    erro          = erro_q;
    db_estado     = estado_q;
  end

endmodule
`default_nettype wire
